inst_loader: RTL and testbench
==============================

INST_LOADER -- requirements
Module: inst_loader

Interface
REQ-001 Parameter PC_DEPTH, 1024: number of instruction memory entries.
REQ-002 Parameter INST_BITS, 128: instruction width; SHALL be an integer multiple of WORD_BITS.
REQ-003 Parameter WORD_BITS, 32: input stream word width; WPI = INST_BITS/WORD_BITS words per instruction.
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  level; its rising edge (registered edge detect) begins a load.
REQ-007 inst_count  input  AW+1  instructions to load; sampled on the start edge; AW = clogb2(PC_DEPTH-1).
REQ-008 abort  input  1  synchronous abort of an active load.
REQ-009 s_data  input  WORD_BITS  stream word.
REQ-010 s_valid  input  1  stream word valid.
REQ-011 s_ready  output  1  loader accepts a word when s_valid && s_ready.
REQ-012 mem_wea  output  1  one-cycle memory write strobe.
REQ-013 mem_addra  output  AW  write address.
REQ-014 mem_dina  output  INST_BITS  write data.
REQ-015 busy  output  1  high in LOAD.
REQ-016 done_pulse  output  1  one-cycle pulse at load completion.
REQ-017 loaded_count  output  AW+1  instructions written in the current/last load.

Function
REQ-018 FSM states IDLE, LOAD, DONE; IDLE->LOAD on start edge with clamped count > 0; IDLE->DONE on start edge with count 0.
REQ-019 Clamp: target = min(inst_count, PC_DEPTH); entry at start edge clears word index, address and loaded_count to 0.
REQ-020 s_ready SHALL be high only in LOAD and only while loaded_count plus in-progress instruction < target; extra words are never accepted.
REQ-021 Word k (0..WPI-1) of an instruction SHALL occupy bits [k*WORD_BITS +: WORD_BITS] (first word in LSBs).
REQ-022 On acceptance of word WPI-1, the next cycle SHALL assert mem_wea for exactly one cycle with mem_addra = current address and mem_dina = assembled instruction; address and loaded_count increment in that same cycle.
REQ-023 s_valid low SHALL stall without losing partial state; no bubble is required between instructions (back-to-back acceptance at one word per cycle).
REQ-024 LOAD->DONE in the cycle after the write of the final instruction; DONE lasts one cycle with done_pulse high, then ->IDLE.
REQ-025 abort in LOAD SHALL discard the partial instruction, suppress any further write, go to IDLE without done_pulse; loaded_count keeps completed writes; abort outside LOAD is ignored.
REQ-026 abort and word WPI-1 acceptance in the same cycle: abort wins, no write.
REQ-027 start edges while in LOAD or DONE SHALL be ignored.
REQ-028 Address never exceeds PC_DEPTH-1; no wrap-around.

Reset
REQ-029 reset SHALL force IDLE asynchronously, with s_ready, mem_wea, busy and done_pulse at 0, mem_addra, mem_dina, loaded_count, word index and start edge register at 0.
REQ-030 reset mid-load SHALL abandon the load with no further memory write.

Configuration
REQ-031 With INST_LOADER_CHECKSUM_EN defined: output checksum [WORD_BITS] SHALL hold the XOR of all words accepted since the last start edge, cleared at the start edge and on reset, with the update visible one cycle after acceptance.
REQ-032 Without INST_LOADER_CHECKSUM_EN: no checksum port and no checksum logic.

Structure
REQ-033 A shared package SHALL hold the FSM state encoding (IDLE, LOAD, DONE), the clogb2 function and the default PC_DEPTH, INST_BITS and WORD_BITS constants.
REQ-034 One sub-module, inst_packer (word-to-instruction shift/assemble with word index), is natural; FSM and address counter stay in inst_loader.

Verification
REQ-035 inst_count=2, 8 words 0x1..0x8 with continuous valid -> writes addr0=0x00000004_00000003_00000002_00000001 and addr1=0x8..0x5, then one done_pulse; loaded_count=2.
REQ-036 inst_count=1 with s_valid toggling every other cycle -> single correct write at addr0, exactly one mem_wea cycle.
REQ-037 inst_count=0 -> done_pulse on the second cycle after the start edge, no mem_wea, s_ready stays 0.
REQ-038 inst_count=PC_DEPTH+5 -> exactly PC_DEPTH writes, last at addr PC_DEPTH-1, s_ready low afterward.
REQ-039 abort after 6 words of inst_count=3 -> one write (addr0), no done_pulse, IDLE, loaded_count=1; a new start then writes from addr0.
REQ-040 reset asserted mid-instruction -> outputs at reset values immediately; with INST_LOADER_CHECKSUM_EN, words 0xA5A5A5A5, 0x0F0F0F0F -> checksum=0xAAAAAAAA.

Source files
------------

// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction loader: FSM encoding, default geometry
// and the clogb2 width helper.
package inst_loader_pkg;

    localparam int DEF_PC_DEPTH  = 32'd1024;
    localparam int DEF_INST_BITS = 32'd128;
    localparam int DEF_WORD_BITS = 32'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bits needed to represent value; never less than one.
    function automatic int clogb2(input int value);
        int r;
        r = 32'd1;
        for (int i = 1; i < 31; i++) begin
            if ((value >> i) != 32'd0) begin
                r = i + 32'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/inst_loader_if.sv
// Control, stream and memory-write bundle of the instruction loader.
interface inst_loader_if
    import inst_loader_pkg::*;
#(
    parameter int PC_DEPTH  = DEF_PC_DEPTH,
    parameter int INST_BITS = DEF_INST_BITS,
    parameter int WORD_BITS = DEF_WORD_BITS
) ();
    localparam int AW = clogb2(PC_DEPTH - 1);

    logic                 start;
    logic [AW:0]          inst_count;
    logic                 abort;
    logic [WORD_BITS-1:0] s_data;
    logic                 s_valid;
    logic                 s_ready;
    logic                 mem_wea;
    logic [AW-1:0]        mem_addra;
    logic [INST_BITS-1:0] mem_dina;
    logic                 busy;
    logic                 done_pulse;
    logic [AW:0]          loaded_count;

    modport master (
        output start, inst_count, abort, s_data, s_valid,
        input  s_ready, mem_wea, mem_addra, mem_dina, busy, done_pulse, loaded_count
    );

    modport slave (
        input  start, inst_count, abort, s_data, s_valid,
        output s_ready, mem_wea, mem_addra, mem_dina, busy, done_pulse, loaded_count
    );
endinterface

// File: rtl/inst_loader_packer.sv
// inst_packer: gathers WORD_BITS stream words into one INST_BITS instruction,
// first word in the least significant bits.
module inst_packer
    import inst_loader_pkg::*;
#(
    parameter int INST_BITS = DEF_INST_BITS,
    parameter int WORD_BITS = DEF_WORD_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 accept,
    input  logic [WORD_BITS-1:0] word,
    output logic                 last,
    output logic [INST_BITS-1:0] assembled
);
    localparam int WPI   = INST_BITS / WORD_BITS;
    localparam int IDX_W = clogb2(WPI - 1);

    logic [IDX_W-1:0]     idx_r;
    logic [INST_BITS-1:0] inst_r;

    assign last = (idx_r == IDX_W'(WPI - 1));

    // Instruction as it stands once the incoming word is merged at its slot.
    always_comb begin
        assembled = inst_r;
        assembled[int'(idx_r) * WORD_BITS +: WORD_BITS] = word;
    end

    // Word index and partial instruction; clear drops any partial state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_r  <= '0;
            inst_r <= '0;
        end else if (clear) begin
            idx_r  <= '0;
            inst_r <= '0;
        end else if (accept) begin
            inst_r <= assembled;
            idx_r  <= last ? '0 : idx_r + IDX_W'(1);
        end else begin
            idx_r  <= idx_r;
            inst_r <= inst_r;
        end
    end
endmodule

// File: rtl/inst_loader.sv
// inst_loader: streams words into instruction memory under an IDLE/LOAD/DONE FSM.
// Optional INST_LOADER_CHECKSUM_EN adds an XOR checksum of accepted words.
module inst_loader
    import inst_loader_pkg::*;
#(
    parameter int PC_DEPTH  = DEF_PC_DEPTH,
    parameter int INST_BITS = DEF_INST_BITS,
    parameter int WORD_BITS = DEF_WORD_BITS
) (
    input  logic               clk,
    input  logic               reset,
    inst_loader_if.slave       bus
`ifdef INST_LOADER_CHECKSUM_EN
    , output logic [WORD_BITS-1:0] checksum
`endif
);
    localparam int AW = clogb2(PC_DEPTH - 1);
    localparam int CW = AW + 1;

    state_t               state_r;
    logic                 start_d_r;
    logic                 start_edge_r;
    logic [CW-1:0]        target_r;
    logic [CW-1:0]        acc_r;
    logic [CW-1:0]        loaded_r;
    logic [AW-1:0]        addr_r;
    logic                 s_ready_r;
    logic                 wea_r;
    logic [INST_BITS-1:0] dina_r;
    logic                 busy_r;
    logic                 done_r;

    logic                 accept_s;
    logic                 last_s;
    logic                 clear_s;
    logic [CW-1:0]        tgt_s;
    logic [INST_BITS-1:0] assembled_s;

    assign accept_s = bus.s_valid & s_ready_r;
    assign clear_s  = ((state_r == ST_IDLE) & start_edge_r) | ((state_r == ST_LOAD) & bus.abort);
    assign tgt_s    = (bus.inst_count > CW'(PC_DEPTH)) ? CW'(PC_DEPTH) : bus.inst_count;

    inst_packer #(.INST_BITS(INST_BITS), .WORD_BITS(WORD_BITS)) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear_s),
        .accept    (accept_s),
        .word      (bus.s_data),
        .last      (last_s),
        .assembled (assembled_s)
    );

    // Registered rising-edge detect on start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_d_r    <= 1'b0;
            start_edge_r <= 1'b0;
        end else begin
            start_d_r    <= bus.start;
            start_edge_r <= bus.start & ~start_d_r;
        end
    end

    // Load FSM, address/count tracking and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            target_r  <= '0;
            acc_r     <= '0;
            loaded_r  <= '0;
            addr_r    <= '0;
            s_ready_r <= 1'b0;
            wea_r     <= 1'b0;
            dina_r    <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            wea_r  <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_edge_r) begin
                        target_r <= tgt_s;
                        acc_r    <= '0;
                        loaded_r <= '0;
                        addr_r   <= '0;
                        if (tgt_s != CW'(0)) begin
                            state_r   <= ST_LOAD;
                            busy_r    <= 1'b1;
                            s_ready_r <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    // A write on the bus this cycle is committed even if abort arrives.
                    if (wea_r) begin
                        loaded_r <= loaded_r + CW'(1);
                        if (addr_r != AW'(PC_DEPTH - 1)) begin
                            addr_r <= addr_r + AW'(1);
                        end
                    end
                    if (bus.abort) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        s_ready_r <= 1'b0;
                    end else if (wea_r && (loaded_r + CW'(1) == target_r)) begin
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                        s_ready_r <= 1'b0;
                        done_r    <= 1'b1;
                    end else if (accept_s && last_s) begin
                        wea_r     <= 1'b1;
                        dina_r    <= assembled_s;
                        acc_r     <= acc_r + CW'(1);
                        s_ready_r <= (acc_r + CW'(1) < target_r);
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    s_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready      = s_ready_r;
    assign bus.mem_wea      = wea_r;
    assign bus.mem_addra    = addr_r;
    assign bus.mem_dina     = dina_r;
    assign bus.busy         = busy_r;
    assign bus.done_pulse   = done_r;
    assign bus.loaded_count = loaded_r;

`ifdef INST_LOADER_CHECKSUM_EN
    logic [WORD_BITS-1:0] csum_r;

    // Running XOR of accepted words, restarted by each accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_r <= '0;
        end else if ((state_r == ST_IDLE) && start_edge_r) begin
            csum_r <= '0;
        end else if (accept_s) begin
            csum_r <= csum_r ^ bus.s_data;
        end else begin
            csum_r <= csum_r;
        end
    end

    assign checksum = csum_r;
`endif
endmodule

// File: tb/tb_inst_loader.sv
// Directed, table-driven bench for inst_loader (default 1024 x 128b, 32b words).
module tb_inst_loader;
    localparam int PC_DEPTH = 1024;
    localparam int AW       = 10;

    typedef struct {
        logic [AW-1:0] addr;
        logic [127:0]  data;
    } wr_t;

    typedef struct {
        int           count;
        bit           toggle;
        int           nwords;
        logic [31:0]  base;
        int           exp_writes;
        int           exp_loaded;
        int           exp_done;
        logic [127:0] exp_first;
    } vec_t;

    logic clk;
    logic reset;
    inst_loader_if #(.PC_DEPTH(PC_DEPTH), .INST_BITS(128), .WORD_BITS(32)) bus ();
`ifdef INST_LOADER_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    inst_loader #(.PC_DEPTH(PC_DEPTH), .INST_BITS(128), .WORD_BITS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef INST_LOADER_CHECKSUM_EN
        , .checksum (checksum)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    wr_t  wr_q[$];
    int   done_cnt = 0;
    int   sr_cnt = 0;
    vec_t vecs[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_wea) wr_q.push_back('{bus.mem_addra, bus.mem_dina});
        if (bus.done_pulse) done_cnt++;
        if (bus.s_ready) sr_cnt++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] inst_of(input logic [31:0] base, input int i);
        logic [31:0] w0, w1, w2, w3;
        w0 = base + 32'(4 * i);
        w1 = w0 + 32'd1;
        w2 = w0 + 32'd2;
        w3 = w0 + 32'd3;
        return {w3, w2, w1, w0};
    endfunction

    task automatic do_start(input int count);
        bus.inst_count = 11'(count);
        bus.start = 1'b1;
        repeat (2) @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic feed(input int nwords, input logic [31:0] base, input bit toggle);
        int k = 0;
        int cyc = 0;
        bit ph = 1'b1;
        bit acc;
        while (k < nwords && cyc < 2 * nwords + 20) begin
            bus.s_valid = toggle ? ph : 1'b1;
            bus.s_data  = base + 32'(k);
            @(negedge clk);
            acc = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            if (acc) k++;
            cyc++;
            ph = ~ph;
        end
        bus.s_valid = 1'b0;
        check("feed_words_accepted", 128'(k), 128'(nwords));
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int wb, db, sb;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.inst_count = '0;
        bus.abort = 1'b0;
        bus.s_data = '0;
        bus.s_valid = 1'b0;
        vecs[0] = '{2, 1'b0, 8,  32'h1,  2, 2, 1, 128'h00000004_00000003_00000002_00000001};
        vecs[1] = '{1, 1'b1, 4,  32'h10, 1, 1, 1, 128'h00000013_00000012_00000011_00000010};
        vecs[2] = '{3, 1'b0, 12, 32'hA0, 3, 3, 1, 128'h000000A3_000000A2_000000A1_000000A0};
        vecs[3] = '{0, 1'b0, 0,  32'h0,  0, 0, 1, 128'h0};
        #1;
        check("rst_s_ready", 128'(bus.s_ready), 128'd0);
        check("rst_busy", 128'(bus.busy), 128'd0);
        check("rst_loaded", 128'(bus.loaded_count), 128'd0);
        tick(3);
        reset = 1'b0;
        tick(2);

        // Table-driven loads
        for (int v = 0; v < 4; v++) begin
            wb = wr_q.size(); db = done_cnt; sb = sr_cnt;
            do_start(vecs[v].count);
            feed(vecs[v].nwords, vecs[v].base, vecs[v].toggle);
            tick(5);
            check($sformatf("v%0d_writes", v), 128'(wr_q.size() - wb), 128'(vecs[v].exp_writes));
            check($sformatf("v%0d_done", v), 128'(done_cnt - db), 128'(vecs[v].exp_done));
            check($sformatf("v%0d_loaded", v), 128'(bus.loaded_count), 128'(vecs[v].exp_loaded));
            check($sformatf("v%0d_busy", v), 128'(bus.busy), 128'd0);
            check($sformatf("v%0d_s_ready_after", v), 128'(bus.s_ready), 128'd0);
            check($sformatf("v%0d_s_ready_seen", v), 128'(sr_cnt != sb), 128'(vecs[v].count != 0));
            if (wr_q.size() > wb) check($sformatf("v%0d_first_data", v), wr_q[wb].data, vecs[v].exp_first);
            for (int i = wb; i < wr_q.size(); i++) begin
                check($sformatf("v%0d_addr%0d", v, i - wb), 128'(wr_q[i].addr), 128'(i - wb));
                check($sformatf("v%0d_data%0d", v, i - wb), wr_q[i].data, inst_of(vecs[v].base, i - wb));
            end
        end

        // Zero count: done_pulse exactly on the second cycle after start rises
        db = done_cnt;
        bus.inst_count = '0;
        bus.start = 1'b1;
        tick(1);
        check("zero_done_c1", 128'(bus.done_pulse), 128'd0);
        tick(1);
        check("zero_done_c2", 128'(bus.done_pulse), 128'd1);
        tick(1);
        check("zero_done_c3", 128'(bus.done_pulse), 128'd0);
        bus.start = 1'b0;
        tick(2);

        // Abort after six words of a three-instruction load
        wb = wr_q.size(); db = done_cnt;
        do_start(3);
        feed(6, 32'h100, 1'b0);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        tick(4);
        check("abort_writes", 128'(wr_q.size() - wb), 128'd1);
        check("abort_done", 128'(done_cnt - db), 128'd0);
        check("abort_busy", 128'(bus.busy), 128'd0);
        check("abort_loaded", 128'(bus.loaded_count), 128'd1);
        if (wr_q.size() > wb) check("abort_data0", wr_q[wb].data, 128'h00000103_00000102_00000101_00000100);
        wb = wr_q.size();
        do_start(1);
        feed(4, 32'h200, 1'b0);
        tick(4);
        check("restart_writes", 128'(wr_q.size() - wb), 128'd1);
        if (wr_q.size() > wb) begin
            check("restart_addr", 128'(wr_q[wb].addr), 128'd0);
            check("restart_data", wr_q[wb].data, 128'h00000203_00000202_00000201_00000200);
        end

        // Abort in the same cycle as the final word: no write
        wb = wr_q.size(); db = done_cnt;
        do_start(1);
        feed(3, 32'h300, 1'b0);
        bus.s_valid = 1'b1;
        bus.s_data = 32'h303;
        bus.abort = 1'b1;
        @(negedge clk);
        check("abort_last_ready", 128'(bus.s_ready), 128'd1);
        tick(1);
        bus.s_valid = 1'b0;
        bus.abort = 1'b0;
        tick(4);
        check("abort_last_writes", 128'(wr_q.size() - wb), 128'd0);
        check("abort_last_done", 128'(done_cnt - db), 128'd0);
        check("abort_last_loaded", 128'(bus.loaded_count), 128'd0);

        // Over-long count is clamped to the memory depth
        wb = wr_q.size(); db = done_cnt;
        do_start(PC_DEPTH + 5);
        feed(4 * PC_DEPTH, 32'h0, 1'b0);
        tick(5);
        check("clamp_writes", 128'(wr_q.size() - wb), 128'(PC_DEPTH));
        check("clamp_last_addr", 128'(wr_q[wr_q.size() - 1].addr), 128'(PC_DEPTH - 1));
        check("clamp_loaded", 128'(bus.loaded_count), 128'(PC_DEPTH));
        check("clamp_done", 128'(done_cnt - db), 128'd1);
        bus.s_valid = 1'b1;
        tick(3);
        check("clamp_s_ready", 128'(bus.s_ready), 128'd0);
        bus.s_valid = 1'b0;
        check("clamp_no_extra", 128'(wr_q.size() - wb), 128'(PC_DEPTH));

        // Reset in the middle of an instruction
        wb = wr_q.size();
        do_start(2);
        feed(6, 32'h400, 1'b0);
        reset = 1'b1;
        #1;
        check("mid_rst_s_ready", 128'(bus.s_ready), 128'd0);
        check("mid_rst_busy", 128'(bus.busy), 128'd0);
        check("mid_rst_wea", 128'(bus.mem_wea), 128'd0);
        check("mid_rst_addr", 128'(bus.mem_addra), 128'd0);
        check("mid_rst_dina", bus.mem_dina, 128'd0);
        check("mid_rst_loaded", 128'(bus.loaded_count), 128'd0);
        check("mid_rst_done", 128'(bus.done_pulse), 128'd0);
        tick(2);
        reset = 1'b0;
        tick(4);
        check("mid_rst_writes", 128'(wr_q.size() - wb), 128'd1);

`ifdef INST_LOADER_CHECKSUM_EN
        do_start(1);
        check("csum_cleared", 128'(checksum), 128'd0);
        feed(1, 32'hA5A5A5A5, 1'b0);
        feed(1, 32'h0F0F0F0F, 1'b0);
        check("csum_value", 128'(checksum), 128'hAAAAAAAA);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        tick(2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
